// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_stream_reader
// Purpose  : Sweeps a wrapping BRAM address range and streams the words out
//            over valid/ready with a last marker.
// Revision : 1.0 - initial release
// ============================================================================
module bram_stream_reader #(
  parameter int DataWidth = 8,
  parameter int Depth     = 1024,
  parameter int AddrWidth = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] length_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_rd_o,
  input  logic [DataWidth-1:0] mem_data_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o
);

  localparam logic [AddrWidth-1:0] c_LAST_ADDR = AddrWidth'(Depth - 1);
  localparam logic [AddrWidth-1:0] c_DEPTH     = AddrWidth'(Depth);
  localparam logic [AddrWidth-1:0] c_ONE       = AddrWidth'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [AddrWidth-1:0]   r_len;
  logic [AddrWidth-1:0]   r_addr;
  logic [AddrWidth-1:0]   r_last_addr;
  logic [AddrWidth-1:0]   r_issued;
  logic [AddrWidth-1:0]   r_emitted;
  logic                   r_inflight;

  logic [DataWidth-1:0]   r_buf [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_count;

  logic                   w_start;
  logic                   w_issue;
  logic                   w_valid;
  logic                   w_pop;
  logic                   w_push;
  logic [2:0]             w_credit;
  logic [AddrWidth-1:0]   w_addr_nxt;

  assign w_start    = (r_state == ST_IDLE) && start_i;
  assign w_valid    = (r_count != 2'd0);
  assign w_pop      = w_valid && ready_i;
  assign w_push     = r_inflight;
  // Words already buffered plus the one returning from the RAM this cycle.
  assign w_credit   = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_addr_nxt = (r_addr == c_LAST_ADDR) ? '0 : r_addr + c_ONE;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = (length_i != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // A same-cycle pop frees a slot, so ready_i feeds the issue decision.
        w_issue = (r_issued < r_len) && (w_credit < (3'd2 + {2'b00, w_pop}));
        if ((r_issued == r_len) && (r_count == 2'd0) && !r_inflight && !w_pop) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len       <= '0;
      r_addr      <= '0;
      r_last_addr <= '0;
      r_issued    <= '0;
      r_emitted   <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_start) begin
        r_len     <= length_i;
        r_addr    <= base_addr_i;
        r_issued  <= '0;
        r_emitted <= '0;
      end else begin
        if (w_issue) begin
          r_addr      <= w_addr_nxt;
          r_last_addr <= r_addr;
          r_issued    <= r_issued + c_ONE;
        end
        if (w_pop) begin
          r_emitted <= r_emitted + c_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= mem_data_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign busy_o     = (r_state == ST_RUN);
  assign done_o     = (r_state == ST_DONE);
  assign mem_rd_o   = w_issue;
  // Outside issue cycles the port holds the most recently issued address.
  assign mem_addr_o = w_issue ? r_addr : r_last_addr;
  assign valid_o    = w_valid;
  assign data_o     = r_buf[r_rd_ptr];
  assign last_o     = w_valid && (r_emitted == (r_len - c_ONE));

`ifndef SYNTHESIS
  a_buf_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_count <= 2'd2);
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_push && (r_count == 2'd2)));
  a_cmd_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_start |-> ((base_addr_i < c_DEPTH) && (length_i <= c_DEPTH)));
  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_stream_reader
// Purpose  : Scoreboard bench; expected words/addresses come from a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_stream_reader;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [AW-1:0] length_i;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_rd_o;
  logic [DW-1:0] mem_data_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;

  bram_stream_reader #(
    .DataWidth(DW),
    .Depth    (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .length_i   (length_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .mem_addr_o (mem_addr_o),
    .mem_rd_o   (mem_rd_o),
    .mem_data_i (mem_data_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o)
  );

  always #5 clk_i = ~clk_i;

  // Single-port RAM with one cycle of registered read latency.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk_i) mem_data_i <= ram[mem_addr_o[3:0]];

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_d_q [$];
  logic          exp_l_q [$];
  logic [AW-1:0] exp_a_q [$];

  int      rmode = 0;
  int      rcyc  = 0;
  int      cyc   = 0;
  int      pop_cnt = 0;
  int      rd_cnt  = 0;
  int      last_pop_cyc = 0;
  bit      tput_en = 0;
  bit      have_prev = 0;
  bit      prev_stall = 0;
  logic [DW-1:0] prev_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none t=%0t", nm, $time);
  endtask

  // Ready pattern generator: 0 = always ready, 1 = 1,0,0 cadence plus a
  // 5-cycle stall, 2 = random.
  initial begin
    ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      case (rmode)
        0:       ready_i = 1'b1;
        1:       ready_i = (rcyc >= 10 && rcyc < 15) ? 1'b0 : ((rcyc % 3) == 0);
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
      rcyc++;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues a read or pops a word.
  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_ni) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall) chk("stall_hold", {valid_o, data_o}, {1'b1, prev_data});
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      if (mem_rd_o) begin
        rd_cnt++;
        if (exp_a_q.size() == 0) fail_now("unexpected_read");
        else chk("rd_addr", mem_addr_o, exp_a_q.pop_front());
      end
      if (valid_o && ready_i) begin
        pop_cnt++;
        if (exp_d_q.size() == 0) begin
          fail_now("unexpected_pop");
        end else begin
          chk("data", data_o, exp_d_q.pop_front());
          chk("last", last_o, exp_l_q.pop_front());
        end
        if (tput_en && have_prev) chk("tput_gap", cyc - last_pop_cyc, 1);
        have_prev    = 1;
        last_pop_cyc = cyc;
      end
      if (mem_rd_o) chk("credit", (rd_cnt - pop_cnt) <= 2, 1);
    end
  end

  task automatic push_expect(input int base, input int len);
    for (int k = 0; k < len; k++) begin
      exp_a_q.push_back(AW'((base + k) % DEPTH));
      exp_d_q.push_back(ram[(base + k) % DEPTH]);
      exp_l_q.push_back(k == len - 1);
    end
  endtask

  task automatic run_xfer(input int base, input int len, input int mode,
                          input bit lat, input bit tput, input bit stray);
    int n;
    bit seen;
    rmode     = mode;
    rcyc      = 0;
    tput_en   = tput;
    have_prev = 0;
    push_expect(base, len);
    start_i     = 1'b1;
    base_addr_i = AW'(base);
    length_i    = AW'(len);
    @(posedge clk_i);
    #1;
    start_i     = 1'b0;
    base_addr_i = AW'($urandom_range(0, 31));
    length_i    = AW'($urandom_range(0, 31));
    n    = 0;
    seen = 0;
    while (!seen && n < 400) begin
      @(negedge clk_i);
      n++;
      if (lat && n == 2) chk("lat_valid_after_e1", valid_o, 0);
      if (lat && n == 3) chk("lat_valid_after_e2", valid_o, 1);
      if (stray && n == 3) begin
        start_i     = 1'b1;
        base_addr_i = AW'(9);
        length_i    = AW'(3);
      end
      if (stray && n == 4) start_i = 1'b0;
      if (done_o) begin
        seen = 1;
        chk("busy_at_done", busy_o, 0);
        chk("queue_drained", exp_d_q.size(), 0);
        if (len == 0) chk("len0_done_cycle", n, 1);
      end else if (n == 1 && len != 0) begin
        chk("busy_run", busy_o, 1);
      end
    end
    if (!seen) fail_now("done_timeout");
    @(negedge clk_i);
    chk("done_pulse_once", {done_o, busy_o}, 0);
    @(posedge clk_i);
    #1;
    exp_a_q.delete();
    exp_d_q.delete();
    exp_l_q.delete();
  endtask

  task automatic randomize_ram();
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
  endtask

  initial begin
    int n;
    int p0;
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    length_i    = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 8'h10);

    repeat (2) @(negedge clk_i);
    chk("reset_state",
        {busy_o, done_o, valid_o, last_o, mem_rd_o, mem_addr_o, data_o}, '0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    run_xfer(0, 4, 0, 1, 1, 0);
    randomize_ram();
    run_xfer(14, 5, 2, 0, 0, 0);
    run_xfer(int'($urandom_range(0, DEPTH - 1)), 8, 1, 0, 0, 1);
    run_xfer(3, 0, 0, 0, 0, 0);

    // Abort after three pops, then a fresh short transfer.
    randomize_ram();
    rmode = 0;
    push_expect(0, 10);
    start_i     = 1'b1;
    base_addr_i = AW'(0);
    length_i    = AW'(10);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    p0 = pop_cnt;
    n  = 0;
    while ((pop_cnt - p0) < 3 && n < 100) begin
      @(posedge clk_i);
      n++;
    end
    if (n >= 100) fail_now("abort_wait_timeout");
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_reset",
        {busy_o, done_o, valid_o, last_o, mem_rd_o, mem_addr_o, data_o}, '0);
    exp_a_q.delete();
    exp_d_q.delete();
    exp_l_q.delete();
    rd_cnt  = 0;
    pop_cnt = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    run_xfer(5, 2, 0, 0, 0, 0);

    randomize_ram();
    run_xfer(3, 16, 2, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      int md;
      randomize_ram();
      md = int'($urandom_range(0, 2));
      run_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
               md, 0, md == 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
